matvec_ntt: RTL and testbench

Computes the NTT-domain matrix–vector product ŵ = Â ∘ v̂ mod q for ML-DSA: ŵ[k][n] = Σ_l Â[k][l][n]·v̂[l][n] mod q. It sits directly downstream of the ExpandA rejection sampler and reads matrix Â from the BRAM that sampler fills (offset k·L·N + l·N + n, 24-bit words). v̂ is read from a vector BRAM and ŵ is written to a result BRAM. Each output coefficient is written exactly once; there is no read-modify-write.

---
 rtl/dilithium_pkg.sv | 16 +
 rtl/matvec_ntt_mod_mul_q.sv | 48 ++++
 rtl/matvec_ntt.sv | 156 +++++++++++++++
 tb/tb_matvec_ntt.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dilithium_pkg.sv
// Shared ML-DSA arithmetic constants and the matvec sequencer state encoding.
package dilithium_pkg;
  localparam int unsigned Q             = 8380417;
  localparam int          COEFF_WIDTH   = 24;
  localparam int          K_DEF         = 8;
  localparam int          L_DEF         = 7;
  localparam int          N_DEF         = 256;
  localparam int unsigned BARRETT_M     = 33587228;
  localparam int          BARRETT_SHIFT = 48;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/matvec_ntt_mod_mul_q.sv
// Two-stage pipelined a*b mod Q (Barrett), carrying an opaque valid/tag alongside.
module mod_mul_q
  import dilithium_pkg::*;
#(
  parameter int TAG_W = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic [COEFF_WIDTH-1:0] a,
  input  logic [COEFF_WIDTH-1:0] b,
  output logic                   out_valid,
  output logic [TAG_W-1:0]       out_tag,
  output logic [COEFF_WIDTH-1:0] r
);
  logic [47:0]      prod;
  logic             v1;
  logic [TAG_W-1:0] t1;
  logic [23:0]      q_est;
  logic [25:0]      r0, r1, r2;

  // Quotient estimate undershoots by at most 2, so the remainder is below 3Q.
  always_comb begin
    q_est = 24'((72'(prod) * 72'(BARRETT_M)) >> BARRETT_SHIFT);
    r0    = 26'(prod) - 26'(48'(q_est) * 48'(Q));
    r1    = (r0 >= 26'(Q)) ? r0 - 26'(Q) : r0;
    r2    = (r1 >= 26'(Q)) ? r1 - 26'(Q) : r1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      t1        <= '0;
      prod      <= '0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      r         <= '0;
    end else begin
      v1        <= in_valid;
      t1        <= in_tag;
      prod      <= 48'(a) * 48'(b);
      out_valid <= v1;
      out_tag   <= t1;
      r         <= r2[COEFF_WIDTH-1:0];
    end
  end
endmodule

// File: rtl/matvec_ntt.sv
// NTT-domain matrix-vector product w[k][n] = sum_l A[k][l][n]*v[l][n] mod Q, one MAC per cycle.
// state    | meaning
// ST_IDLE  | waiting for start
// ST_RUN   | issuing one A/v read pair per cycle
// ST_DRAIN | all reads issued, waiting for the final write
module matvec_ntt #(
  parameter int K           = dilithium_pkg::K_DEF,
  parameter int L           = dilithium_pkg::L_DEF,
  parameter int N           = dilithium_pkg::N_DEF,
  parameter int COEFF_WIDTH = dilithium_pkg::COEFF_WIDTH,
  localparam int AW_A = $clog2(K * L * N),
  localparam int AW_V = $clog2(L * N),
  localparam int AW_W = $clog2(K * N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [AW_A-1:0]        addr_matA,
  input  logic [COEFF_WIDTH-1:0] dout_matA,
  output logic [AW_V-1:0]        addr_v,
  input  logic [COEFF_WIDTH-1:0] dout_v,
  output logic                   we_w,
  output logic [AW_W-1:0]        addr_w,
  output logic [COEFF_WIDTH-1:0] din_w
);
  import dilithium_pkg::*;

  localparam int LW    = (L > 1) ? $clog2(L) : 1;
  localparam int NW    = (N > 1) ? $clog2(N) : 1;
  localparam int TAG_W = AW_W + 2;

  state_e            state;
  logic [LW-1:0]     l_cnt;
  logic [NW-1:0]     n_cnt;
  logic [AW_W-1:0]   g_cnt;
  logic [AW_A-1:0]   a_ptr, row_base;
  logic [AW_V-1:0]   v_ptr;
  logic              l_last, n_last, issue_last, final_write;

  logic              s1_valid, s1_first, s1_last;
  logic [AW_W-1:0]   s1_g;
  logic              mm_valid, mm_first, mm_last;
  logic [AW_W-1:0]   mm_g;
  logic [TAG_W-1:0]  mm_tag;
  logic [COEFF_WIDTH-1:0] mm_r, acc, acc_sum, acc_n;

  assign addr_matA   = a_ptr;
  assign addr_v      = v_ptr;
  assign busy        = (state != ST_IDLE);
  assign l_last      = (l_cnt == LW'(L - 1));
  assign n_last      = (n_cnt == NW'(N - 1));
  assign issue_last  = l_last && (g_cnt == AW_W'(K * N - 1));
  assign final_write = we_w && (addr_w == AW_W'(K * N - 1));

  // Address walk uses running pointers; row_base tracks k*L*N without a multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      l_cnt    <= '0;
      n_cnt    <= '0;
      g_cnt    <= '0;
      a_ptr    <= '0;
      row_base <= '0;
      v_ptr    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state    <= ST_RUN;
          l_cnt    <= '0;
          n_cnt    <= '0;
          g_cnt    <= '0;
          a_ptr    <= '0;
          row_base <= '0;
          v_ptr    <= '0;
        end
        ST_RUN: begin
          if (issue_last) state <= ST_DRAIN;
          if (!l_last) begin
            l_cnt <= l_cnt + LW'(1);
            a_ptr <= a_ptr + AW_A'(N);
            v_ptr <= v_ptr + AW_V'(N);
          end else begin
            l_cnt <= '0;
            g_cnt <= g_cnt + AW_W'(1);
            if (n_last) begin
              n_cnt    <= '0;
              v_ptr    <= '0;
              row_base <= row_base + AW_A'(L * N);
              a_ptr    <= row_base + AW_A'(L * N);
            end else begin
              n_cnt <= n_cnt + NW'(1);
              v_ptr <= AW_V'(n_cnt) + AW_V'(1);
              a_ptr <= row_base + AW_A'(n_cnt) + AW_A'(1);
            end
          end
        end
        ST_DRAIN: if (final_write) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Tag travels one cycle behind the issue, aligned with the returning BRAM data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_g     <= '0;
    end else begin
      s1_valid <= (state == ST_RUN);
      s1_first <= (l_cnt == '0);
      s1_last  <= l_last;
      s1_g     <= g_cnt;
    end
  end

  mod_mul_q #(.TAG_W(TAG_W)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_tag    ({s1_first, s1_last, s1_g}),
    .a         (dout_matA),
    .b         (dout_v),
    .out_valid (mm_valid),
    .out_tag   (mm_tag),
    .r         (mm_r)
  );

  assign {mm_first, mm_last, mm_g} = mm_tag;

  always_comb begin
    acc_sum = (mm_first ? '0 : acc) + mm_r;
    acc_n   = (acc_sum >= COEFF_WIDTH'(Q)) ? acc_sum - COEFF_WIDTH'(Q) : acc_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      we_w   <= 1'b0;
      din_w  <= '0;
      addr_w <= '0;
      done   <= 1'b0;
    end else begin
      we_w <= mm_valid && mm_last;
      done <= (state == ST_DRAIN) && final_write;
      if (mm_valid) acc <= acc_n;
      if (mm_valid && mm_last) begin
        din_w  <= acc_n;
        addr_w <= mm_g;
      end
    end
  end
endmodule

// File: tb/tb_matvec_ntt.sv
// Bench for matvec_ntt: a default-size and a K=4/L=4 instance checked against a golden matvec model.
module tb_matvec_ntt;
  localparam int QQ = 8380417;
  localparam int NN = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  always #5 clk = ~clk;

  logic        busy0, done0, we0, busy1, done1, we1;
  logic [13:0] aa0;
  logic [10:0] av0, aw0;
  logic [11:0] aa1;
  logic [9:0]  av1, aw1;
  logic [23:0] da0, dv0, dw0, da1, dv1, dw1;

  matvec_ntt dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .addr_matA(aa0), .dout_matA(da0), .addr_v(av0), .dout_v(dv0),
    .we_w(we0), .addr_w(aw0), .din_w(dw0));

  matvec_ntt #(.K(4), .L(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .addr_matA(aa1), .dout_matA(da1), .addr_v(av1), .dout_v(dv1),
    .we_w(we1), .addr_w(aw1), .din_w(dw1));

  logic [23:0] ma [2][14336];
  logic [23:0] mv [2][1792];
  always @(posedge clk) begin
    da0 <= ma[0][aa0];
    dv0 <= mv[0][av0];
    da1 <= ma[1][aa1];
    dv1 <= mv[1][av1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int kk(input int d); return (d != 0) ? 4 : 8; endfunction
  function automatic int ll(input int d); return (d != 0) ? 4 : 7; endfunction

  // stimulus-owned
  int chk_en = 0, phase = 0, tmo = 0, s0 = 0;
  // compare-owned
  int checks = 0, failures = 0, phase_done = -1;
  bit act [2];
  int sc [2], nwr [2], ndone [2];
  int dcyc [2][8];
  int gold [2][2048];
  int wm [2][2048];

  task automatic chk(input string nm, input int d, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, d, cyc, got, want);
    end
  endtask

  function automatic logic [23:0] pick(input int mode);
    int r;
    if (mode == 0) return 24'd0;
    if (mode == 2) return 24'(QQ - 1);
    r = $urandom_range(9, 0);
    if (r == 0) return 24'(QQ - 1);
    if (r == 1) return 24'd0;
    return 24'($urandom_range(QQ - 1, 0));
  endfunction

  // mode 0: zeros, 1: A=1 and v[l][n]=n, 2: all Q-1, 3: random
  task automatic fill(input int d, input int mode);
    for (int l = 0; l < ll(d); l++)
      for (int n = 0; n < NN; n++)
        mv[d][l*NN + n] = (mode == 1) ? 24'(n) : pick(mode);
    for (int k = 0; k < kk(d); k++)
      for (int l = 0; l < ll(d); l++)
        for (int n = 0; n < NN; n++)
          ma[d][(k*ll(d) + l)*NN + n] = (mode == 1) ? 24'd1 : pick(mode);
  endtask

  task automatic compute_gold(input int d);
    longint unsigned s;
    for (int k = 0; k < kk(d); k++)
      for (int n = 0; n < NN; n++) begin
        s = 0;
        for (int l = 0; l < ll(d); l++)
          s = (s + longint'(ma[d][(k*ll(d) + l)*NN + n]) * longint'(mv[d][l*NN + n])) % QQ;
        gold[d][k*NN + n] = int'(s);
      end
  endtask

  always @(negedge clk) begin
    int T, off, i, g, L;
    bit eb, ed, ew;
    logic [63:0] bz, dn, we, aw, dw, aa, av, st;
    if (chk_en != 0) begin
      if (phase != phase_done) begin
        chk("timeouts", 0, 64'(tmo), 64'd0);
        case (phase)
          0: begin
            chk("rst_addr_w", 0, 64'(aw0), 0);  chk("rst_din_w", 0, 64'(dw0), 0);
            chk("rst_addr_a", 0, 64'(aa0), 0);  chk("rst_addr_v", 0, 64'(av0), 0);
            chk("rst_addr_w", 1, 64'(aw1), 0);  chk("rst_din_w", 1, 64'(dw1), 0);
          end
          1: begin
            chk("done_count", 0, 64'(ndone[0]), 2);
            chk("done_cycle_1", 0, 64'(dcyc[0][0] - s0), 14341);
            chk("done_cycle_2", 0, 64'(dcyc[0][1] - s0), 28682);
            chk("gold_w3_255", 0, 64'(gold[0][3*NN + 255]), 1785);
            chk("dut_w3_255", 0, 64'(wm[0][3*NN + 255]), 1785);
          end
          2: begin
            chk("no_done_after_rst", 0, 64'(ndone[0]), 2);
            chk("gold_qm1", 0, 64'(gold[0][2047]), 7);
            chk("dut_w0_qm1", 0, 64'(wm[0][0]), 7);
          end
          3: chk("done_after_restart", 0, 64'(ndone[0]), 3);
          4: chk("small_done_count", 1, 64'(ndone[1]), 3);
          default: ;
        endcase
        phase_done = phase;
      end
      for (int d = 0; d < 2; d++) begin
        bz = (d != 0) ? 64'(busy1) : 64'(busy0);
        dn = (d != 0) ? 64'(done1) : 64'(done0);
        we = (d != 0) ? 64'(we1)   : 64'(we0);
        aw = (d != 0) ? 64'(aw1)   : 64'(aw0);
        dw = (d != 0) ? 64'(dw1)   : 64'(dw0);
        aa = (d != 0) ? 64'(aa1)   : 64'(aa0);
        av = (d != 0) ? 64'(av1)   : 64'(av0);
        st = (d != 0) ? 64'(start1) : 64'(start0);
        L = ll(d);
        T = kk(d) * NN * L;
        ed = act[d] && (cyc == sc[d] + T + 5);
        eb = act[d] && (cyc > sc[d]) && !ed;
        off = cyc - sc[d] - 4 - L;
        ew = act[d] && off >= 0 && (off % L) == 0 && (off / L) < kk(d) * NN;
        chk("busy", d, bz, 64'(eb));
        chk("done", d, dn, 64'(ed));
        chk("we_w", d, we, 64'(ew));
        if (ew && we == 64'd1) begin
          g = off / L;
          chk("addr_w", d, aw, 64'(g));
          chk("din_w", d, dw, 64'(gold[d][g]));
          wm[d][g] = int'(dw);
          nwr[d]++;
        end
        i = cyc - sc[d] - 1;
        if (act[d] && i >= 0 && i < T) begin
          chk("addr_matA", d, aa, 64'((i / (NN*L)) * L * NN + (i % L) * NN + (i / L) % NN));
          chk("addr_v", d, av, 64'((i % L) * NN + (i / L) % NN));
        end
        if (dn == 64'd1) begin
          dcyc[d][ndone[d] % 8] = cyc;
          ndone[d]++;
        end
        if (ed) begin
          chk("write_count", d, 64'(nwr[d]), 64'(kk(d) * NN));
          act[d] = 1'b0;
        end
        if (rst) act[d] = 1'b0;
        if (st == 64'd1 && !act[d] && !rst) begin
          act[d] = 1'b1;
          sc[d]  = cyc;
          nwr[d] = 0;
          compute_gold(d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int d);
    tick();
    if (d != 0) start1 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int d, input int target, input int budget);
    int c;
    c = 0;
    while (ndone[d] < target && c < budget) begin
      tick();
      c++;
    end
    if (ndone[d] < target) begin
      tmo++;
      $display("FAIL wait_done dut%0d: done count %0d, required %0d", d, ndone[d], target);
    end
  endtask

  initial begin
    int sb;
    fill(0, 0);
    fill(1, 0);
    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1;

    // zero matrix, ignored start at +100, second run with A=1, v=n started on the done cycle
    tick();
    start0 = 1'b1;
    s0 = cyc;
    tick();
    start0 = 1'b0;
    while (cyc < s0 + 100) tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    while (cyc < s0 + 14341) tick();
    fill(0, 1);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_done(0, 2, 20000);
    tick();
    phase = 1;
    tick();

    // all Q-1 with a mid-run reset, then a random restart
    fill(0, 2);
    tick();
    start0 = 1'b1;
    sb = cyc;
    tick();
    start0 = 1'b0;
    while (cyc < sb + 5000) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (50) tick();
    phase = 2;
    tick();
    fill(0, 3);
    pulse(0);
    wait_done(0, 3, 20000);
    tick();
    phase = 3;
    tick();

    // K=4, L=4 instance, three random data sets
    for (int s = 0; s < 3; s++) begin
      fill(1, 3);
      pulse(1);
      wait_done(1, s + 1, 6000);
      tick();
    end
    phase = 4;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
